bf_loop_stack_core: RTL and testbench
=====================================

BF_LOOP_STACK_CORE -- requirements
Module: bf_loop_stack_core

Interface
REQ-001 SHALL have parameter DATA_ADDR_WIDTH, default 15: data cell address width.
REQ-002 SHALL have parameter PROG_ADDR_WIDTH, default 15: program address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, legal values >=8: cell and bus value width.
REQ-004 SHALL have parameter STACK_DEPTH, default 16, legal values >=1: loop-return stack entries.
REQ-005 SHALL have parameter DEPTH_WIDTH, default 12: forward-scan nesting counter width.
REQ-006 SHALL have parameter ADDR_WIDTH, default 15, legal values >= max(DATA_ADDR_WIDTH, PROG_ADDR_WIDTH).
REQ-007 SHALL have port clock, input, 1 bit: clock, rising edge.
REQ-008 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port enable, input, 1 bit: advance when high.
REQ-010 SHALL have port bus_req, output, 1 bit: transaction request.
REQ-011 SHALL have port bus_ack, input, 1 bit: transaction complete; read data valid this cycle.
REQ-012 SHALL have port bus_op, output, 3 bits, encoded as: 0 None, 1 ReadProg, 2 ReadData, 3 WriteData, 4 ReadIo, 5 WriteIo.
REQ-013 SHALL have ports addr (output, ADDR_WIDTH), val_out (output, DATA_WIDTH) and val_in (input, DATA_WIDTH).
REQ-014 SHALL have port halted, output, 1 bit: set in HALT.
REQ-015 SHALL have port error, output, 2 bits, encoded as: 0 none, 1 stack overflow, 2 unmatched ']', 3 end of program inside a '[' scan.

Function
REQ-016 SHALL implement states FETCH, DECODE, LOAD, EXEC, STORE, IN, OUT, SCAN, HALT.
REQ-017 SHALL decode bus_req, bus_op, addr and val_out combinationally from state.
REQ-018 SHALL assert bus_req only in FETCH, LOAD, STORE, IN, OUT and SCAN.
REQ-019 SHALL, in any non-bus state, drive bus_op=0, addr=0 and val_out=0.
REQ-020 SHALL, in a bus state, hold op/addr/val stable until bus_ack is sampled high with enable high; completion occurs on that edge.
REQ-021 SHALL ignore bus_ack when bus_req is low or enable is low.
REQ-022 SHALL freeze all registers and state while enable is low; outputs then hold their values.
REQ-023 FETCH SHALL perform ReadProg at addr=pc; on ack: instr<=val_in[7:0], pc<=pc+1, go to DECODE.
REQ-024 DECODE (1 cycle) SHALL act on instr:
- '>': cursor+1, then FETCH.
- '<': cursor-1, then FETCH.
- '+', '-', '.', '[', ']': go to LOAD.
- ',': go to IN.
- 0x00: go to HALT with error 0.
- any other byte: go to FETCH.
REQ-025 LOAD SHALL perform ReadData at addr=cursor; on ack: acc<=val_in, go to EXEC.
REQ-026 EXEC (1 cycle) SHALL act on instr:
- '+': acc+1, then STORE.
- '-': acc-1, then STORE.
- '.': go to OUT.
- '[' with acc!=0: push pc, then FETCH; if the stack is full, go to HALT with error 1 and leave the stack unchanged.
- '[' with acc==0: depth<=0, then SCAN.
- ']' with the stack empty: go to HALT with error 2.
- ']' with acc!=0: pc<=top, no pop, then FETCH.
- ']' with acc==0: pop, then FETCH.
REQ-027 STORE SHALL perform WriteData at addr=cursor with val_out=acc, then FETCH.
REQ-028 IN SHALL perform ReadIo with addr=0; on ack: acc<=val_in, then STORE.
REQ-029 OUT SHALL perform WriteIo with addr=0 and val_out=acc, then FETCH.
REQ-030 SCAN SHALL perform ReadProg at addr=pc; on ack pc<=pc+1 and act on val_in[7:0]:
- '[': depth+1.
- ']' with depth==0: go to FETCH.
- ']' with depth!=0: depth-1.
- 0x00: go to HALT with error 3.
- any other byte: remain in SCAN.
REQ-031 HALT SHALL be held until reset, with halted=1, error held and bus_req=0.
REQ-032 SHALL apply modulo-2^width wrap to acc, cursor, pc and depth; wrap is not flagged.
REQ-033 SHALL store entries of PROG_ADDR_WIDTH bits in the stack, with a stack pointer wide enough to represent 0..STACK_DEPTH.
REQ-034 SHALL take 5 cycles for '+' with bus_ack tied high: FETCH, DECODE, LOAD, EXEC, STORE.

Reset
REQ-035 SHALL, while reset is high, clear pc, cursor, acc, depth, sp, instr and error, and set state to FETCH.
REQ-036 SHALL force bus_req=0, bus_op=0, addr=0, val_out=0 and halted=0 while reset is high; reset overrides enable.
REQ-037 SHALL, on the first cycle after reset falls, drive bus_req=1, bus_op=1, addr=0.
REQ-038 SHALL, on reset mid-transaction or mid-SCAN, abandon the transaction with no write completed.

Verification
REQ-039 With bus_ack=1 and program "+++.\0": WriteIo with val_out=3 occurs; cell0=3; halted=1; error=0.
REQ-040 With program "++[>+<-]>.\0": the stack peaks at sp=1 and returns to 0; output is 2; cell0=0, cell1=2.
REQ-041 With cell0=0 and program "[+[-]+]." : SCAN skips the nested body, depth returns to 0, output is 0, and no data writes occur.
REQ-042 With program "]" : halted=1 and error=2; with STACK_DEPTH=2 and program "+[[[" : error=1 and sp=2.
REQ-043 With bus_ack delayed 3 cycles per transaction and enable pulsed low mid-run on "+.\0": bus signals stay stable while pending, and output remains 1.
REQ-044 With reset asserted during SCAN of "[" then released: the next request is ReadProg at addr 0, and sp=0, error=0.

Source files
------------

// File: rtl/bf_loop_stack_core.sv
// Brainfuck interpreter core: a multi-cycle FSM on a shared request/ack bus,
// with a hardware loop-return stack and a forward scan over skipped loops.
module bf_loop_stack_core #(
  parameter int DATA_ADDR_WIDTH = 15,
  parameter int PROG_ADDR_WIDTH = 15,
  parameter int DATA_WIDTH      = 8,
  parameter int STACK_DEPTH     = 16,
  parameter int DEPTH_WIDTH     = 12,
  parameter int ADDR_WIDTH      = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  bus_req,
  input  logic                  bus_ack,
  output logic [2:0]            bus_op,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] val_out,
  input  logic [DATA_WIDTH-1:0] val_in,
  output logic                  halted,
  output logic [1:0]            error
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE    = PROG_ADDR_WIDTH'(1);
  localparam logic [DATA_ADDR_WIDTH-1:0] CUR_ONE   = DATA_ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]      ACC_ONE   = DATA_WIDTH'(1);
  localparam logic [DEPTH_WIDTH-1:0]     DEPTH_ONE = DEPTH_WIDTH'(1);
  localparam logic [SP_W-1:0]            SP_ONE    = SP_W'(1);
  localparam logic [SP_W-1:0]            SP_FULL   = SP_W'(STACK_DEPTH);

  localparam logic [7:0] CH_RIGHT = 8'h3E;
  localparam logic [7:0] CH_LEFT  = 8'h3C;
  localparam logic [7:0] CH_INC   = 8'h2B;
  localparam logic [7:0] CH_DEC   = 8'h2D;
  localparam logic [7:0] CH_OUT   = 8'h2E;
  localparam logic [7:0] CH_IN    = 8'h2C;
  localparam logic [7:0] CH_OPEN  = 8'h5B;
  localparam logic [7:0] CH_CLOSE = 8'h5D;
  localparam logic [7:0] CH_NUL   = 8'h00;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LOAD, S_EXEC, S_STORE, S_IN, S_OUT, S_SCAN, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE, OP_RD_PROG, OP_RD_DATA, OP_WR_DATA, OP_RD_IO, OP_WR_IO
  } bus_op_e;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_OVERFLOW, ERR_UNMATCHED, ERR_SCAN_EOP
  } err_e;

  state_e                     state_q, state_d;
  logic [PROG_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_ADDR_WIDTH-1:0] cursor_q, cursor_d;
  logic [DATA_WIDTH-1:0]      acc_q, acc_d;
  logic [DEPTH_WIDTH-1:0]     depth_q, depth_d;
  logic [SP_W-1:0]            sp_q, sp_d;
  logic [7:0]                 instr_q, instr_d;
  err_e                       error_q, error_d;
  logic [PROG_ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic            ack_ok, push, stack_full, stack_empty;
  logic [SP_W-1:0] sp_m1;
  logic [IDX_W-1:0] push_idx, top_idx;
  bus_op_e         op_c;

  // A transaction completes only on an edge where both ack and enable are high.
  assign ack_ok      = enable & bus_ack;
  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);
  assign sp_m1       = sp_q - SP_ONE;
  assign push_idx    = IDX_W'(sp_q);
  assign top_idx     = IDX_W'(sp_m1);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cursor_d = cursor_q;
    acc_d    = acc_q;
    depth_d  = depth_q;
    sp_d     = sp_q;
    instr_d  = instr_q;
    error_d  = error_q;
    push     = 1'b0;
    case (state_q)
      S_FETCH: if (ack_ok) begin
        instr_d = val_in[7:0];
        pc_d    = pc_q + PC_ONE;
        state_d = S_DECODE;
      end
      S_DECODE: case (instr_q)
        CH_RIGHT: begin cursor_d = cursor_q + CUR_ONE; state_d = S_FETCH; end
        CH_LEFT:  begin cursor_d = cursor_q - CUR_ONE; state_d = S_FETCH; end
        CH_INC, CH_DEC, CH_OUT, CH_OPEN, CH_CLOSE: state_d = S_LOAD;
        CH_IN:    state_d = S_IN;
        CH_NUL:   begin error_d = ERR_NONE; state_d = S_HALT; end
        default:  state_d = S_FETCH;
      endcase
      S_LOAD: if (ack_ok) begin
        acc_d   = val_in;
        state_d = S_EXEC;
      end
      S_EXEC: case (instr_q)
        CH_INC: begin acc_d = acc_q + ACC_ONE; state_d = S_STORE; end
        CH_DEC: begin acc_d = acc_q - ACC_ONE; state_d = S_STORE; end
        CH_OUT: state_d = S_OUT;
        CH_OPEN: if (acc_q == '0) begin
          depth_d = '0;
          state_d = S_SCAN;
        end else if (stack_full) begin
          error_d = ERR_OVERFLOW;
          state_d = S_HALT;
        end else begin
          push    = 1'b1;
          sp_d    = sp_q + SP_ONE;
          state_d = S_FETCH;
        end
        CH_CLOSE: if (stack_empty) begin
          error_d = ERR_UNMATCHED;
          state_d = S_HALT;
        end else begin
          // Loop back keeps the entry; only the final exit pops it.
          if (acc_q != '0) pc_d = stack_q[top_idx];
          else             sp_d = sp_m1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
      S_STORE, S_OUT: if (ack_ok) state_d = S_FETCH;
      S_IN: if (ack_ok) begin
        acc_d   = val_in;
        state_d = S_STORE;
      end
      S_SCAN: if (ack_ok) begin
        pc_d = pc_q + PC_ONE;
        case (val_in[7:0])
          CH_OPEN:  depth_d = depth_q + DEPTH_ONE;
          CH_CLOSE: if (depth_q == '0) state_d = S_FETCH;
                    else               depth_d = depth_q - DEPTH_ONE;
          CH_NUL:   begin error_d = ERR_SCAN_EOP; state_d = S_HALT; end
          default:  ;
        endcase
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      cursor_q <= '0;
      acc_q    <= '0;
      depth_q  <= '0;
      sp_q     <= '0;
      instr_q  <= '0;
      error_q  <= ERR_NONE;
    end else if (enable) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cursor_q <= cursor_d;
      acc_q    <= acc_d;
      depth_q  <= depth_d;
      sp_q     <= sp_d;
      instr_q  <= instr_d;
      error_q  <= error_d;
    end
  end

  // NOTE: the return stack is plain storage and is not reset; sp alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (!reset && enable && push) stack_q[push_idx] <= pc_q;
  end

  always_comb begin
    bus_req = 1'b0;
    op_c    = OP_NONE;
    addr    = '0;
    val_out = '0;
    if (!reset) begin
      case (state_q)
        S_FETCH, S_SCAN: begin
          bus_req = 1'b1; op_c = OP_RD_PROG; addr = ADDR_WIDTH'(pc_q);
        end
        S_LOAD: begin
          bus_req = 1'b1; op_c = OP_RD_DATA; addr = ADDR_WIDTH'(cursor_q);
        end
        S_STORE: begin
          bus_req = 1'b1; op_c = OP_WR_DATA; addr = ADDR_WIDTH'(cursor_q); val_out = acc_q;
        end
        S_IN:  begin bus_req = 1'b1; op_c = OP_RD_IO; end
        S_OUT: begin bus_req = 1'b1; op_c = OP_WR_IO; val_out = acc_q; end
        default: ;
      endcase
    end
  end

  assign bus_op = op_c;
  assign halted = (state_q == S_HALT) && !reset;
  assign error  = error_q;

endmodule

// File: tb/tb_bf_loop_stack_core.sv
// Self-checking bench: a program-level interpreter predicts the bus transaction
// stream; a negedge bus agent serves memory and compares every completed transaction.
module tb_bf_loop_stack_core;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int SD = 2;
  localparam logic [2:0] OP_RP = 3'd1, OP_RD = 3'd2, OP_WD = 3'd3, OP_RI = 3'd4, OP_WI = 3'd5;

  typedef struct packed {
    logic [2:0]    op;
    logic [AW-1:0] a;
    logic [7:0]    v;
  } tx_t;

  logic          clock = 1'b0, reset = 1'b1, enable = 1'b1, bus_ack = 1'b0;
  logic          bus_req, halted;
  logic [2:0]    bus_op;
  logic [AW-1:0] addr;
  logic [DW-1:0] val_out, val_in = '0;
  logic [1:0]    error;

  bf_loop_stack_core #(.STACK_DEPTH(SD)) dut (
    .clock(clock), .reset(reset), .enable(enable), .bus_req(bus_req), .bus_ack(bus_ack),
    .bus_op(bus_op), .addr(addr), .val_out(val_out), .val_in(val_in),
    .halted(halted), .error(error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_fail = 0;
  logic [7:0] prog [256];
  logic [7:0] dmem [int];
  logic [7:0] io_log [$];
  tx_t        exp_q [$];
  logic [7:0] io_in_val = 8'h41;
  int  m_err, m_sp;
  int  ack_delay = 0, wait_cnt = 0, cyc = 0, first_pc1 = -1, sp_peak = 0, n_dwr = 0;
  bit  en_pulse = 0, ack_idle = 0, chk_en = 0, pend_v = 0;
  tx_t pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic tx_t mk(input logic [2:0] op, input int a, input logic [7:0] v);
    tx_t t;
    t.op = op;
    t.a  = AW'(a);
    t.v  = v;
    return t;
  endfunction

  function automatic logic [7:0] prog_at(input int a);
    return (a >= 0 && a < 256) ? prog[a] : 8'h00;
  endfunction

  // Program-level interpreter: walks the Brainfuck program and lists bus traffic.
  task automatic build_model();
    logic [7:0] mm [int];
    int pc = 0, cur = 0, depth, steps = 0;
    logic [7:0] acc, c, b;
    int stk [$];
    bit done = 0;
    exp_q.delete();
    m_err = 0;
    while (!done && steps < 20000) begin
      steps++;
      exp_q.push_back(mk(OP_RP, pc, 0));
      c  = prog_at(pc);
      pc = (pc + 1) % 32768;
      if (c == ">") cur = (cur + 1) % 32768;
      else if (c == "<") cur = (cur + 32767) % 32768;
      else if (c == 8'h00) done = 1;
      else if (c == ",") begin
        acc = io_in_val;
        exp_q.push_back(mk(OP_RI, 0, 0));
        exp_q.push_back(mk(OP_WD, cur, acc));
        mm[cur] = acc;
      end else if (c == "+" || c == "-" || c == "." || c == "[" || c == "]") begin
        acc = mm.exists(cur) ? mm[cur] : 8'h00;
        exp_q.push_back(mk(OP_RD, cur, 0));
        if (c == "+" || c == "-") begin
          acc = (c == "+") ? acc + 8'd1 : acc - 8'd1;
          exp_q.push_back(mk(OP_WD, cur, acc));
          mm[cur] = acc;
        end else if (c == ".") begin
          exp_q.push_back(mk(OP_WI, 0, acc));
        end else if (c == "[") begin
          if (acc != 0) begin
            if (stk.size() == SD) begin m_err = 1; done = 1; end
            else stk.push_back(pc);
          end else begin
            depth = 0;
            forever begin
              exp_q.push_back(mk(OP_RP, pc, 0));
              b  = prog_at(pc);
              pc = (pc + 1) % 32768;
              if (b == "[") depth++;
              else if (b == "]") begin
                if (depth == 0) break;
                depth--;
              end else if (b == 8'h00) begin m_err = 3; done = 1; break; end
            end
          end
        end else begin
          if (stk.size() == 0) begin m_err = 2; done = 1; end
          else if (acc != 0) pc = stk[$];
          else void'(stk.pop_back());
        end
      end
    end
    m_sp = stk.size();
  endtask

  // Bus agent and compare process: drives inputs and samples outputs on the falling edge.
  always @(negedge clock) begin
    tx_t t, e;
    if (reset) begin
      enable   = 1'b0;
      bus_ack  = 1'b0;
      wait_cnt = 0;
      pend_v   = 0;
      cyc      = 0;
    end else begin
      enable = !(en_pulse && (cyc % 3 == 1));
      if (int'(dut.sp_q) > sp_peak) sp_peak = int'(dut.sp_q);
      if (bus_req) begin
        t = mk(bus_op, int'(addr), val_out);
        if (pend_v && chk_en) check("pending_stable", t, pend);
        pend   = t;
        pend_v = 1;
        if (wait_cnt >= ack_delay) begin
          bus_ack = 1'b1;
          case (bus_op)
            OP_RP:   val_in = prog_at(int'(addr));
            OP_RD:   val_in = dmem.exists(int'(addr)) ? dmem[int'(addr)] : 8'h00;
            OP_RI:   val_in = io_in_val;
            default: val_in = 8'($urandom);
          endcase
        end else begin
          bus_ack = 1'b0;
          val_in  = 8'($urandom);
        end
        if (enable && bus_ack) begin
          if (chk_en) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL extra_tx: got op %0d addr %0d, expected none", bus_op, addr);
            end else begin
              e = exp_q.pop_front();
              check("tx_op", bus_op, e.op);
              check("tx_addr", addr, e.a);
              if (bus_op == OP_WD || bus_op == OP_WI) check("tx_val", val_out, e.v);
            end
          end
          if (bus_op == OP_WD) begin dmem[int'(addr)] = val_out; n_dwr++; end
          if (bus_op == OP_WI) io_log.push_back(val_out);
          if (bus_op == OP_RP && addr == 1 && first_pc1 < 0) first_pc1 = cyc;
          wait_cnt = 0;
          pend_v   = 0;
        end else if (enable) begin
          wait_cnt++;
        end
      end else begin
        bus_ack  = ack_idle;
        val_in   = 8'($urandom);
        pend_v   = 0;
        wait_cnt = 0;
      end
      cyc++;
    end
  end

  task automatic check_reset_outputs();
    check("rst_req", bus_req, 0);
    check("rst_op", bus_op, 0);
    check("rst_addr", addr, 0);
    check("rst_val", val_out, 0);
    check("rst_halted", halted, 0);
  endtask

  task automatic release_and_check_first();
    @(posedge clock); #1 reset = 1'b0; chk_en = 1;
    @(negedge clock); #1;
    check("first_req", bus_req, 1);
    check("first_op", bus_op, OP_RP);
    check("first_addr", addr, 0);
  endtask

  task automatic start_prog(input string p, input int dly, input bit enp);
    @(posedge clock); #1 reset = 1'b1; chk_en = 0;
    for (int i = 0; i < 256; i++) prog[i] = (i < p.len()) ? p[i] : 8'h00;
    dmem.delete();
    io_log.delete();
    n_dwr = 0; first_pc1 = -1; sp_peak = 0;
    ack_delay = dly; en_pulse = enp; ack_idle = (dly == 0);
    build_model();
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    check_reset_outputs();
    check("rst_error", error, 0);
    release_and_check_first();
  endtask

  task automatic finish_prog(input string tag);
    int n = 0;
    while (!halted && n < 5000) begin @(negedge clock); n++; end
    if (!halted) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no halt after %0d cycles, expected halt", tag, n);
    end
    @(negedge clock); #1;
    check({tag, "_halted"}, halted, 1);
    check({tag, "_error"}, error, m_err);
    check({tag, "_tx_left"}, exp_q.size(), 0);
    check({tag, "_sp"}, dut.sp_q, m_sp);
    check({tag, "_idle_req"}, bus_req, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    start_prog("+++.", 0, 0);
    finish_prog("p1");
    check("p1_err_lit", error, 0);
    check("p1_nout", io_log.size(), 1);
    check("p1_out", io_log.size() > 0 ? io_log[0] : 8'hxx, 3);
    check("p1_cell0", dmem.exists(0) ? dmem[0] : 8'h00, 3);
    check("p1_plus_cycles", first_pc1, 5);

    start_prog("++[>+<-]>.", 0, 0);
    finish_prog("p2");
    check("p2_out", io_log.size() > 0 ? io_log[0] : 8'hxx, 2);
    check("p2_cell0", dmem.exists(0) ? dmem[0] : 8'h00, 0);
    check("p2_cell1", dmem.exists(1) ? dmem[1] : 8'h00, 2);
    check("p2_sp_peak", sp_peak, 1);
    check("p2_sp_end", dut.sp_q, 0);

    start_prog("[+[-]+].", 1, 0);
    finish_prog("p3");
    check("p3_out", io_log.size() > 0 ? io_log[0] : 8'hxx, 0);
    check("p3_data_writes", n_dwr, 0);
    check("p3_depth", dut.depth_q, 0);

    start_prog("]", 0, 0);
    finish_prog("p4");
    check("p4_err_lit", error, 2);

    start_prog("+[[[", 0, 0);
    finish_prog("p5");
    check("p5_err_lit", error, 1);
    check("p5_sp_lit", dut.sp_q, 2);

    start_prog("+.", 3, 1);
    finish_prog("p6");
    check("p6_out", io_log.size() > 0 ? io_log[0] : 8'hxx, 1);

    start_prog(",+.", 2, 0);
    finish_prog("p7");
    check("p7_out", io_log.size() > 0 ? io_log[0] : 8'hxx, 8'h42);
    check("p7_cell0", dmem.exists(0) ? dmem[0] : 8'h00, 8'h42);

    start_prog("<-.", 0, 1);
    finish_prog("p8");
    check("p8_out", io_log.size() > 0 ? io_log[0] : 8'hxx, 8'hFF);
    check("p8_cell_wrap", dmem.exists(32767) ? dmem[32767] : 8'h00, 8'hFF);

    start_prog("[", 3, 0);
    n = 0;
    while (!(bus_req && bus_op == OP_RP && addr == 1) && n < 200) begin @(negedge clock); n++; end
    check("p9_reached_scan", {bus_req, bus_op, 12'(addr)}, {1'b1, OP_RP, 12'd1});
    @(posedge clock); #1 reset = 1'b1; chk_en = 0;
    @(negedge clock); #1;
    check_reset_outputs();
    build_model();
    @(posedge clock);
    release_and_check_first();
    check("p9_sp_after_rst", dut.sp_q, 0);
    check("p9_err_after_rst", error, 0);
    check("p9_no_writes", n_dwr, 0);
    finish_prog("p9");
    check("p9_err_lit", error, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
